// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter in front of a single shared RAM port.
// Define ARB_STARVE_GUARD_EN to let a waiting instruction fetch win after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic        ram_ready,
    input  logic [31:0] ramload,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        wr_q, wr_d;
    logic [7:0]  wait_q, wait_d;
    logic        data_req;
    logic        instr_turn;

    assign data_req = dREN | dWEN;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_CNT = 3'(STARVE_LIMIT);

    logic [2:0] starve_q, starve_d;

    assign instr_turn = iREN && (starve_q == STARVE_CNT);
`else
    assign instr_turn = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        store_d     = store_q;
        wr_d        = wr_q;
        wait_d      = wait_q;
`ifdef ARB_STARVE_GUARD_EN
        starve_d    = starve_q;
`endif
        ihit        = 1'b0;
        dhit        = 1'b0;
        iload       = '0;
        dload       = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        timeout_err = 1'b0;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (data_req && !instr_turn) begin
                    state_d = DGRANT;
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
`ifdef ARB_STARVE_GUARD_EN
                    // Saturates so a late instruction request still sees the limit.
                    if (starve_q != STARVE_CNT) starve_d = starve_q + 3'd1;
`endif
                end else if (iREN) begin
                    state_d = IGRANT;
                    addr_d  = iaddr;
                    store_d = '0;
                    wr_d    = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
                    starve_d = '0;
`endif
                end
            end

            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
                if (wait_q == TIMEOUT_CNT) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end else if (ram_ready) begin
                    ihit    = 1'b1;
                    iload   = ramload;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            DGRANT: begin
                ramREN   = !wr_q;
                ramWEN   = wr_q;
                ramaddr  = addr_q;
                ramstore = store_q;
                if (wait_q == TIMEOUT_CNT) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end else if (ram_ready) begin
                    dhit    = 1'b1;
                    dload   = wr_q ? 32'd0 : ramload;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            wait_q   <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
            wait_q   <= wait_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= starve_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        ihit, dhit, ramREN, ramWEN, timeout_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ram_ready(ram_ready), .ramload(ramload), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    // Model: the access currently owning the RAM, and how many data grants in a row were given.
    typedef struct {
        bit          valid;
        bit          is_instr;
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] store;
        int          waited;
    } access_t;

    access_t cur;
    int      data_streak;

    logic        obs_ihit, obs_dhit, obs_ren, obs_wen, obs_to;
    logic [31:0] obs_iload, obs_dload, obs_addr, obs_store;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the inputs already driven: predict, compare mid-cycle, then advance the model.
    task automatic cycle();
        logic        e_ihit, e_dhit, e_ren, e_wen, e_to, instr_turn;
        logic [31:0] e_iload, e_dload, e_addr, e_store;
        e_ihit = 0; e_dhit = 0; e_ren = 0; e_wen = 0; e_to = 0;
        e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
        if (cur.valid) begin
            e_ren   = cur.is_instr || !cur.is_write;
            e_wen   = !cur.is_instr && cur.is_write;
            e_addr  = cur.addr;
            e_store = cur.is_instr ? 32'd0 : cur.store;
            if (cur.waited == TIMEOUT) e_to = 1;
            else if (ram_ready) begin
                if (cur.is_instr) begin e_ihit = 1; e_iload = ramload; end
                else begin e_dhit = 1; e_dload = cur.is_write ? 32'd0 : ramload; end
            end
        end
        @(negedge CLK);
        obs_ihit = ihit; obs_dhit = dhit; obs_iload = iload; obs_dload = dload;
        obs_ren = ramREN; obs_wen = ramWEN; obs_addr = ramaddr; obs_store = ramstore;
        obs_to = timeout_err;
        check("ihit", 32'(ihit), 32'(e_ihit));
        check("dhit", 32'(dhit), 32'(e_dhit));
        check("iload", iload, e_iload);
        check("dload", dload, e_dload);
        check("ramREN", 32'(ramREN), 32'(e_ren));
        check("ramWEN", 32'(ramWEN), 32'(e_wen));
        check("ramaddr", ramaddr, e_addr);
        check("ramstore", ramstore, e_store);
        check("timeout_err", 32'(timeout_err), 32'(e_to));
        @(posedge CLK);
        if (RST) begin
            cur.valid   = 0;
            data_streak = 0;
        end else if (cur.valid) begin
            if (e_to || e_ihit || e_dhit) cur.valid = 0;
            else cur.waited++;
        end else begin
`ifdef ARB_STARVE_GUARD_EN
            instr_turn = iREN && (data_streak >= STARVE_LIMIT);
`else
            instr_turn = 0;
`endif
            if ((dREN || dWEN) && !instr_turn) begin
                cur = '{1, 0, dWEN, daddr, dstore, 0};
                if (data_streak < STARVE_LIMIT) data_streak++;
            end else if (iREN) begin
                cur = '{1, 1, 0, iaddr, 32'd0, 0};
                data_streak = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    endtask

    task automatic do_reset();
        RST = 1; idle_inputs();
        cycle();
        RST = 0;
    endtask

    initial begin
        int          n;
        int          instr_grants;
        bit          seen;
        logic [31:0] grants[$];

        RST = 1; idle_inputs();
        cur = '{0, 0, 0, 32'd0, 32'd0, 0};
        data_streak = 0;
        repeat (2) @(posedge CLK);
        #1;
        // Reset state, with requests pending that must not be granted while reset is held.
        iREN = 1; dREN = 1; iaddr = 32'h10; daddr = 32'h20;
        repeat (3) cycle();
        check("no_grant_in_reset", 32'(obs_ren | obs_wen), 32'd0);
        do_reset();

        // Instruction fetch, RAM ready three cycles into the grant.
        iREN = 1; iaddr = 32'h40;
        cycle();
        iREN = 0;
        repeat (3) cycle();
        check("ifetch_addr", obs_addr, 32'h40);
        ram_ready = 1; ramload = 32'hDEADBEEF;
        cycle();
        check("ifetch_hit", 32'(obs_ihit), 32'd1);
        check("ifetch_load", obs_iload, 32'hDEADBEEF);
        cycle();
        check("ifetch_hit_one_cycle", 32'(obs_ihit), 32'd0);
        ram_ready = 0;

        // Simultaneous write and fetch: data first, one idle cycle, then the fetch.
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
        cycle();
        dWEN = 0; ram_ready = 1; ramload = 32'hCAFEF00D;
        cycle();
        check("wr_ramWEN", 32'(obs_wen), 32'd1);
        check("wr_ramstore", obs_store, 32'h12345678);
        check("wr_dhit", 32'(obs_dhit), 32'd1);
        cycle();
        check("b2b_idle_gap", 32'(obs_ren | obs_wen), 32'd0);
        cycle();
        check("b2b_ihit", 32'(obs_ihit), 32'd1);
        check("b2b_iaddr", obs_addr, 32'h44);
        iREN = 0; ram_ready = 0;
        cycle();

        // RAM never answers: abort after TIMEOUT waiting cycles.
        dREN = 1; daddr = 32'h300;
        cycle();
        dREN = 0;
        n = 0; seen = 0;
        while (!seen && n < TIMEOUT + 20) begin
            cycle();
            n++;
            if (obs_dhit) check("timeout_no_hit", 32'(obs_dhit), 32'd0);
            seen = obs_to;
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_cycle", 32'(n), 32'(TIMEOUT + 1));
        cycle();
        check("timeout_idle", {obs_addr[29:0], obs_ren, obs_wen}, 32'd0);

        // Reset in the second cycle of a data grant drops the access.
        dREN = 1; daddr = 32'h500;
        cycle();
        dREN = 0;
        cycle();
        RST = 1;
        cycle();
        RST = 0; ram_ready = 1; ramload = 32'h55AA55AA;
        cycle();
        check("rst_mid_grant_hit", 32'(obs_dhit), 32'd0);
        check("rst_mid_grant_ram", 32'(obs_ren | obs_wen), 32'd0);
        dREN = 1; daddr = 32'h504;
        cycle();
        dREN = 0;
        cycle();
        check("post_rst_dhit", 32'(obs_dhit), 32'd1);
        check("post_rst_dload", obs_dload, 32'h55AA55AA);
        ram_ready = 0;
        cycle();

        // Data request dropped right after the grant still completes exactly once.
        dREN = 1; daddr = 32'h600;
        cycle();
        dREN = 0;
        cycle();
        ram_ready = 1; ramload = 32'h0BADF00D;
        n = 0;
        repeat (4) begin cycle(); if (obs_dhit) n++; end
        check("drop_req_one_hit", 32'(n), 32'd1);
        ram_ready = 0;

        // Continuous data traffic against a waiting fetch.
        do_reset();
        iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h200; ram_ready = 1; ramload = 32'h1;
        repeat (20) begin
            cycle();
            if (obs_ren) grants.push_back(obs_addr);
        end
        instr_grants = 0;
        foreach (grants[i]) if (grants[i] == 32'h100) instr_grants++;
        check("starve_grant_count", 32'(grants.size()), 32'd10);
`ifdef ARB_STARVE_GUARD_EN
        check("starve_5th_is_instr", grants[4], 32'h100);
        check("starve_instr_grants", 32'(instr_grants), 32'd2);
`else
        check("strict_data_5th", grants[4], 32'h200);
        check("strict_instr_grants", 32'(instr_grants), 32'd0);
`endif
        idle_inputs();
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            RST       = ($urandom_range(0, 199) == 0);
            iREN      = ($urandom_range(0, 1) == 0);
            dREN      = ($urandom_range(0, 2) == 0);
            dWEN      = ($urandom_range(0, 3) == 0);
            iaddr     = $urandom;
            daddr     = $urandom;
            dstore    = $urandom;
            ram_ready = ($urandom_range(0, 2) == 0);
            ramload   = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
